mips_trace_buffer: RTL and testbench

Parametrised instruction-trace capture buffer for the MIPS single-cycle core. Taps the core's PC, instruction and data-memory buses and records qualifying retired instructions into a DEPTH-entry first-word-fall-through buffer, which the testbench or a debug port drains with a valid/ready handshake. Adds optional PC-match triggering, a write-only filter and a choice of stop-on-full or wrap-around (keep newest) capture.

---
 rtl/mips_trace_buffer.sv | 94 +++++++++
 tb/tb_mips_trace_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: FWFT trace buffer recording qualifying retired MIPS instructions, with trigger, filter and wrap modes.
module mips_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] writedata,
  input  logic              memwrite,
  input  logic              retire_valid,
  input  logic              arm,
  input  logic              stop,
  input  logic              cfg_wrap,
  input  logic              cfg_wr_only,
  input  logic              cfg_trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_instr,
  output logic [DATA_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_memwrite,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [1:0]        state
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, FULL} state_t;
  state_t st;
  logic [DATA_W-1:0] m_pc [DEPTH];
  logic [DATA_W-1:0] m_instr [DEPTH];
  logic [DATA_W-1:0] m_addr [DEPTH];
  logic [DATA_W-1:0] m_data [DEPTH];
  logic [DEPTH-1:0] m_mw;
  logic [AW-1:0] wp, rp;
  logic qual, hit, full, pop, cap, push, ovr, drop, clr;
  always_comb begin
    qual = retire_valid & (~cfg_wr_only | memwrite);
    hit = retire_valid & (pc == trig_pc);
    full = count == CNT_W'(DEPTH);
    clr = arm & ~stop;
    pop = rd_valid & rd_ready & ~clr;
    cap = ~stop & ~arm & qual & (st == CAPTURE | (st == ARMED & hit));
    push = cap & (~full | pop | cfg_wrap);
    ovr = push & full & ~pop;
    drop = cap & full & ~pop & ~cfg_wrap;
  end
  assign rd_valid = count != '0;
  assign state = st;
  assign rd_pc = m_pc[rp];
  assign rd_instr = m_instr[rp];
  assign rd_addr = m_addr[rp];
  assign rd_data = m_data[rp];
  assign rd_memwrite = m_mw[rp];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      st <= cfg_trig_en ? ARMED : CAPTURE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wp <= wp + AW'(1);
      // an overwrite in wrap mode retires the oldest entry exactly like a pop
      if (pop | ovr) rp <= rp + AW'(1);
      count <= count + CNT_W'(push & ~ovr) - CNT_W'(pop);
      if (ovr | drop | (st == FULL & qual & ~stop)) overflow <= 1'b1;
      st <= stop ? IDLE :
            (st == ARMED & hit) ? CAPTURE :
            drop ? FULL :
            (st == FULL & pop) ? CAPTURE : st;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      m_pc[wp] <= pc;
      m_instr[wp] <= instr;
      m_addr[wp] <= aluout;
      m_data[wp] <= writedata;
      m_mw[wp] <= memwrite;
    end
  end
endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb_mips_trace_buffer: directed test-plan scenarios plus randomized traffic checked against a queue-based model.
module tb_mips_trace_buffer;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [DW-1:0] pc, instr, addr, data;
    logic mw;
  } ent_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] pc = '0, instr = '0, aluout = '0, writedata = '0, trig_pc = '0;
  logic memwrite = 1'b0, retire_valid = 1'b0, arm = 1'b0, stop = 1'b0;
  logic cfg_wrap = 1'b0, cfg_wr_only = 1'b0, cfg_trig_en = 1'b0, rd_ready = 1'b0;
  logic rd_valid, rd_memwrite, overflow;
  logic [DW-1:0] rd_pc, rd_instr, rd_addr, rd_data;
  logic [CW-1:0] count;
  logic [1:0] state;
  ent_t q[$];
  int ms = 0;
  logic movf = 1'b0;
  int total = 0;
  int bad = 0;

  mips_trace_buffer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instr(instr), .aluout(aluout),
    .writedata(writedata), .memwrite(memwrite), .retire_valid(retire_valid),
    .arm(arm), .stop(stop), .cfg_wrap(cfg_wrap), .cfg_wr_only(cfg_wr_only),
    .cfg_trig_en(cfg_trig_en), .trig_pc(trig_pc), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_memwrite(rd_memwrite), .count(count),
    .overflow(overflow), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    check("rd_valid", 160'(rd_valid), 160'(q.size() != 0));
    check("count", 160'(count), 160'(q.size()));
    check("state", 160'(state), 160'(ms));
    check("overflow", 160'(overflow), 160'(movf));
    if (q.size() != 0)
      check("head", 160'({rd_pc, rd_instr, rd_addr, rd_data, rd_memwrite}), 160'(q[0]));
  endtask

  // Model: 0=IDLE 1=ARMED 2=CAPTURE 3=FULL; the queue holds the buffer contents oldest first.
  task automatic model_step();
    bit pop = (q.size() != 0) && rd_ready;
    bit qual = retire_valid && (!cfg_wr_only || memwrite);
    bit hit = retire_valid && (pc == trig_pc);
    int s0 = ms;
    int n0 = q.size();
    ent_t e = {pc, instr, aluout, writedata, memwrite};
    if (stop) begin
      if (pop) void'(q.pop_front());
      ms = 0;
      return;
    end
    if (arm) begin
      q.delete();
      movf = 1'b0;
      ms = cfg_trig_en ? 1 : 2;
      return;
    end
    if (pop) void'(q.pop_front());
    if (s0 == 1 && hit) ms = 2;
    if ((s0 == 2 || (s0 == 1 && hit)) && qual) begin
      if (n0 < DEPTH || pop) q.push_back(e);
      else if (cfg_wrap) begin
        void'(q.pop_front());
        q.push_back(e);
        movf = 1'b1;
      end else begin
        movf = 1'b1;
        ms = 3;
      end
    end else if (s0 == 3) begin
      if (qual) movf = 1'b1;
      if (pop) ms = 2;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_step();
    #1;
    arm = 1'b0;
    stop = 1'b0;
  endtask

  task automatic retire(input logic [DW-1:0] p, input logic mw);
    retire_valid = 1'b1;
    pc = p;
    instr = $urandom;
    aluout = $urandom;
    writedata = $urandom;
    memwrite = mw;
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_count", 160'(count), 160'(0));
    check("rst_state", 160'(state), 160'(0));
    check("rst_valid", 160'(rd_valid), 160'(0));
    check("rst_ovf", 160'(overflow), 160'(0));
    q.delete();
    ms = 0;
    movf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic restart(input logic wrap, input logic wr_only, input logic trig_en);
    stop = 1'b1;
    tick();
    cfg_wrap = wrap;
    cfg_wr_only = wr_only;
    cfg_trig_en = trig_en;
    arm = 1'b1;
    tick();
  endtask

  initial begin
    int n;
    logic [DW-1:0] last;
    #2;
    do_reset();
    // basic capture
    restart(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) retire(DW'(4 * i), 1'b0);
    check("basic_count", 160'(count), 160'(5));
    check("basic_head", 160'(rd_pc), 160'(0));
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("basic_rd", 160'(rd_pc), 160'(4 * i));
      tick();
    end
    check("basic_empty", 160'(rd_valid), 160'(0));
    rd_ready = 1'b0;
    // trigger
    trig_pc = 32'h20;
    restart(1'b0, 1'b0, 1'b1);
    for (int i = 0; i <= 16; i++) begin
      if (i <= 8) check("trig_armed", 160'(state), 160'(1));
      retire(DW'(4 * i), 1'b0);
    end
    check("trig_head", 160'(rd_pc), 160'(32'h20));
    check("trig_count", 160'(count), 160'(9));
    // stop-on-full
    restart(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) retire(DW'(4 * i), 1'b0);
    check("full_state", 160'(state), 160'(3));
    check("full_count", 160'(count), 160'(16));
    check("full_ovf", 160'(overflow), 160'(1));
    rd_ready = 1'b1;
    tick();
    check("full_pop_state", 160'(state), 160'(2));
    last = '0;
    for (int i = 0; i < 15; i++) begin
      last = rd_pc;
      tick();
    end
    check("full_last", 160'(last), 160'(32'h3c));
    rd_ready = 1'b0;
    // wrap
    restart(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) retire(DW'(4 * i), 1'b0);
    check("wrap_count", 160'(count), 160'(16));
    check("wrap_ovf", 160'(overflow), 160'(1));
    check("wrap_head", 160'(rd_pc), 160'(32'h10));
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      last = rd_pc;
      tick();
    end
    check("wrap_last", 160'(last), 160'(32'h4c));
    // filter with concurrent reads
    restart(1'b0, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      check("filter_cnt_le1", 160'(count <= 1), 160'(1));
      if (rd_valid) begin
        n++;
        check("filter_mw", 160'(rd_memwrite), 160'(1));
      end
      if (i < 8) retire(DW'(4 * i), (i % 2) == 0);
      else tick();
    end
    check("filter_reads", 160'(n), 160'(4));
    rd_ready = 1'b0;
    // async reset mid-capture, then arm while FULL
    restart(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) retire(DW'(4 * i), 1'b0);
    check("mid_count", 160'(count), 160'(7));
    do_reset();
    arm = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) retire(DW'(4 * i), 1'b1);
    check("rearm_full", 160'(state), 160'(3));
    arm = 1'b1;
    tick();
    check("rearm_count", 160'(count), 160'(0));
    check("rearm_ovf", 160'(overflow), 160'(0));
    check("rearm_state", 160'(state), 160'(2));
    for (int i = 0; i < 3; i++) retire(DW'(32'h100 + 4 * i), 1'b0);
    check("rearm_new", 160'(count), 160'(3));
    // randomized segments
    for (int s = 0; s < 6; s++) begin
      trig_pc = DW'(4 * $urandom_range(0, 15));
      restart(1'($urandom), 1'($urandom), 1'($urandom));
      for (int c = 0; c < 200; c++) begin
        retire_valid = 1'($urandom_range(0, 3) != 0);
        pc = DW'(4 * $urandom_range(0, 15));
        instr = $urandom;
        aluout = $urandom;
        writedata = $urandom;
        memwrite = 1'($urandom);
        rd_ready = 1'($urandom_range(0, 2) == 0);
        arm = 1'($urandom_range(0, 59) == 0);
        stop = 1'($urandom_range(0, 79) == 0);
        tick();
      end
      retire_valid = 1'b0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
